// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared types and constants for the NES memory initiator.
// Holds the FSM state enum, the requester ID enum and the region prefixes
// found on address bits [21:18] of the unified memory map.
package nes_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_PPU = 1'b1
   } req_id_t;

   // Region prefixes on addr[21:18]; a region matches when (top & MASK) == PREFIX.
   localparam logic [3:0] REGION_PRG           = 4'b0000;
   localparam logic [3:0] REGION_PRG_MASK      = 4'b1000;
   localparam logic [3:0] REGION_CHR           = 4'b1000;
   localparam logic [3:0] REGION_CHR_MASK      = 4'b1100;
   localparam logic [3:0] REGION_VRAM          = 4'b1100;
   localparam logic [3:0] REGION_VRAM_MASK     = 4'b1111;
   localparam logic [3:0] REGION_CPU_RAM       = 4'b1110;
   localparam logic [3:0] REGION_CPU_RAM_MASK  = 4'b1111;
   localparam logic [3:0] REGION_CART_RAM      = 4'b1111;
   localparam logic [3:0] REGION_CART_RAM_MASK = 4'b1111;

   // True when the 4-bit address prefix falls inside the given region.
   function automatic logic region_hit(input logic [3:0] top,
                                       input logic [3:0] prefix,
                                       input logic [3:0] mask);
      return (top & mask) == prefix;
   endfunction

endpackage

// File: rtl/nes_mem_arb_pick.sv
// nes_mem_arb_pick: chooses which requester gets the next bus grant.
// Default build: fixed priority, PPU over CPU.
// With NES_MEM_ARB_RR_EN defined: round-robin on ties, pointer advances to the
// other requester after every grant; a lone requester always wins.
module nes_mem_arb_pick
   import nes_mem_pkg::*;
(
`ifdef NES_MEM_ARB_RR_EN
   input  logic    clock,
   input  logic    reset_n,
   input  logic    grant_taken,
`endif
   input  logic    cpu_req,
   input  logic    ppu_req,
   output req_id_t winner
);

`ifdef NES_MEM_ARB_RR_EN
   req_id_t ptr_q;

   // Round-robin pointer: after a grant, favour the requester that lost.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= REQ_CPU;
      end else if (grant_taken) begin
         ptr_q <= (winner == REQ_CPU) ? REQ_PPU : REQ_CPU;
      end
   end

   // Tie goes to the pointed requester, otherwise whoever is asking.
   always_comb begin
      winner = REQ_CPU;
      if (cpu_req && ppu_req) begin
         winner = ptr_q;
      end else if (ppu_req) begin
         winner = REQ_PPU;
      end
   end
`else
   // Fixed priority: PPU wins whenever it is requesting.
   always_comb begin
      winner = REQ_CPU;
      if (ppu_req) begin
         winner = REQ_PPU;
      end
   end
`endif

endmodule

// File: rtl/nes_mem_initiator.sv
// nes_mem_initiator: bus master of the NES unified memory interface.
// Arbitrates CPU/PPU requests, drives one strobe per access on the shared
// bus, captures read data after RD_LAT cycles and acks the requester.
// Optional round-robin arbitration: define NES_MEM_ARB_RR_EN.
module nes_mem_initiator
   import nes_mem_pkg::*;
#(
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned ADDR_W = 22
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ppu_req,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic              ppu_ack,
   output logic [7:0]        ppu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_cpu,
   output logic              mem_rd_ppu,
   output logic              mem_wr,
   output logic [7:0]        mem_d,
   input  logic [7:0]        mem_q_cpu,
   input  logic [7:0]        mem_q_ppu,
   output logic              busy
);

   state_t            state_q;
   state_t            state_d;
   req_id_t           winner;
   req_id_t           who_q;
   logic              we_q;
   logic [7:0]        wdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        cnt_q;
   logic              grant;
   logic              capture;

   nes_mem_arb_pick u_arb (
`ifdef NES_MEM_ARB_RR_EN
      .clock       (clock),
      .reset_n     (reset_n),
      .grant_taken (grant),
`endif
      .cpu_req     (cpu_req),
      .ppu_req     (ppu_req),
      .winner      (winner)
   );

   assign mem_addr = addr_q;
   assign busy     = (state_q != ST_IDLE);

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and bus/ack outputs; outputs depend only on registered state.
   always_comb begin
      state_d    = state_q;
      grant      = 1'b0;
      capture    = 1'b0;
      mem_rd_cpu = 1'b0;
      mem_rd_ppu = 1'b0;
      mem_wr     = 1'b0;
      mem_d      = '0;
      cpu_ack    = 1'b0;
      ppu_ack    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_done && (cpu_req || ppu_req)) begin
               grant   = 1'b1;
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (who_q == REQ_CPU && we_q) begin
               mem_wr  = 1'b1;
               mem_d   = wdata_q;
               state_d = ST_DONE;
            end else begin
               if (who_q == REQ_CPU) begin
                  mem_rd_cpu = 1'b1;
               end else begin
                  mem_rd_ppu = 1'b1;
               end
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (who_q == REQ_CPU) begin
               cpu_ack = 1'b1;
            end else begin
               ppu_ack = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Transaction registers: latch winner fields at grant, count read latency,
   // capture read data into the requester's rdata register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         who_q     <= REQ_CPU;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         cpu_rdata <= '0;
         ppu_rdata <= '0;
      end else begin
         if (grant) begin
            who_q   <= winner;
            we_q    <= (winner == REQ_CPU) && cpu_we;
            wdata_q <= cpu_wdata;
            addr_q  <= (winner == REQ_CPU) ? cpu_addr : ppu_addr;
         end
         if (state_q == ST_STROBE) begin
            cnt_q <= 3'(RD_LAT - 1);
         end else if (state_q == ST_WAIT && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (capture) begin
            if (who_q == REQ_CPU) begin
               cpu_rdata <= mem_q_cpu;
            end else begin
               ppu_rdata <= mem_q_ppu;
            end
         end
      end
   end

endmodule

// File: tb/tb_nes_mem_initiator.sv
// tb_nes_mem_initiator: directed plus random transactions for nes_mem_initiator,
// checked against a transaction-level reference (arbitration order, strobe
// kind/address/data, ack timing, returned data). Honours NES_MEM_ARB_RR_EN.
module tb_nes_mem_initiator;
   import nes_mem_pkg::*;

   localparam int unsigned TB_LAT = 2;
   localparam int unsigned AW     = 22;

   logic          clock     = 1'b0;
   logic          reset_n   = 1'b0;
   logic          load_done = 1'b0;
   logic          cpu_req   = 1'b0;
   logic          cpu_we    = 1'b0;
   logic [AW-1:0] cpu_addr  = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          ppu_req   = 1'b0;
   logic [AW-1:0] ppu_addr  = '0;
   logic [7:0]    mem_q_cpu = '0;
   logic [7:0]    mem_q_ppu = '0;
   logic          cpu_ack, ppu_ack, mem_rd_cpu, mem_rd_ppu, mem_wr, busy;
   logic [7:0]    cpu_rdata, ppu_rdata, mem_d;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   nes_mem_initiator #(.RD_LAT(TB_LAT), .ADDR_W(AW)) dut (
      .clock(clock), .reset_n(reset_n), .load_done(load_done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
      .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
      .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu),
      .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory contents seen by the bench: distinct per address and per side.
   function automatic logic [7:0] mem_val(input logic [AW-1:0] a, input bit ppu);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ (ppu ? 8'hA5 : 8'h5A);
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [3:0] pre;
      case ($urandom_range(0, 4))
         0:       pre = REGION_PRG | (4'($urandom) & ~REGION_PRG_MASK);
         1:       pre = REGION_CHR | (4'($urandom) & ~REGION_CHR_MASK);
         2:       pre = REGION_VRAM;
         3:       pre = REGION_CPU_RAM;
         default: pre = REGION_CART_RAM;
      endcase
      return {pre, 18'($urandom)};
   endfunction

   // ---------------- bus observation ----------------
   typedef struct { int kind; logic [AW-1:0] addr; logic [7:0] d; int cyc; } strb_t;
   typedef struct { int who; int cyc; logic [7:0] crd; logic [7:0] prd; } ack_t;
   strb_t sq[$];
   ack_t  aq[$];
   logic [AW-1:0] cur_addr   = '0;
   int            rsp_c_cyc  = -1;
   int            rsp_p_cyc  = -1;
   logic [AW-1:0] rsp_c_addr = '0;
   logic [AW-1:0] rsp_p_addr = '0;

   // Memory responder: read data is valid only in the cycle RD_LAT after the strobe.
   initial forever begin
      @(posedge clock); #1;
      mem_q_cpu = (cyc == rsp_c_cyc) ? mem_val(rsp_c_addr, 1'b0) : ~mem_val(rsp_c_addr, 1'b0);
      mem_q_ppu = (cyc == rsp_p_cyc) ? mem_val(rsp_p_addr, 1'b1) : ~mem_val(rsp_p_addr, 1'b1);
   end

   // Bus monitor: invariants each cycle, records strobes and acks.
   initial begin
      strb_t s;
      ack_t  a;
      forever begin
         @(negedge clock);
         chk("bus_strobe_excl", 32'($onehot0({mem_rd_cpu, mem_rd_ppu, mem_wr})), 32'd1);
         if (!mem_wr) chk("bus_mem_d_idle", 32'(mem_d), 32'd0);
         if (mem_rd_cpu || mem_rd_ppu || mem_wr) begin
            s.kind = mem_wr ? 3 : (mem_rd_ppu ? 2 : 1);
            s.addr = mem_addr;
            s.d    = mem_d;
            s.cyc  = cyc;
            sq.push_back(s);
            cur_addr = mem_addr;
            if (mem_rd_cpu) begin rsp_c_cyc = cyc + int'(TB_LAT); rsp_c_addr = mem_addr; end
            if (mem_rd_ppu) begin rsp_p_cyc = cyc + int'(TB_LAT); rsp_p_addr = mem_addr; end
         end else if (busy) begin
            chk("bus_addr_hold", 32'(mem_addr), 32'(cur_addr));
         end
         a.cyc = cyc; a.crd = cpu_rdata; a.prd = ppu_rdata;
         if (cpu_ack) begin a.who = 0; aq.push_back(a); end
         if (ppu_ack) begin a.who = 1; aq.push_back(a); end
      end
   end

   // ---------------- reference model ----------------
   bit            m_ptr_ppu = 1'b0;
   logic [7:0]    m_crd = '0;
   logic [7:0]    m_prd = '0;
   bit            g_c_on, g_c_we, g_p_on;
   logic [AW-1:0] g_c_addr, g_p_addr;
   logic [7:0]    g_c_wd;
   int            last_ack_cyc = 0;

   function automatic bit model_pick_ppu(input bit c, input bit p);
`ifdef NES_MEM_ARB_RR_EN
      if (c && p) return m_ptr_ppu;
`endif
      return p;
   endfunction

   task automatic model_ptr_set(input bit v);
`ifdef NES_MEM_ARB_RR_EN
      m_ptr_ppu = v;
`else
      m_ptr_ppu = 1'b0 & v;
`endif
   endtask

   task automatic txn_start(input bit c_on, input bit c_we, input logic [AW-1:0] c_addr,
                            input logic [7:0] c_wd, input bit p_on, input logic [AW-1:0] p_addr);
      g_c_on = c_on; g_c_we = c_we; g_c_addr = c_addr; g_c_wd = c_wd;
      g_p_on = p_on; g_p_addr = p_addr;
      cpu_req = c_on; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      ppu_req = p_on; ppu_addr = p_addr;
   endtask

   // Wait for all acks (bounded), then compare observed bus activity with the model.
   task automatic txn_finish(input int t0);
      int n, got, budget, exp_strb, lat, kind;
      bit first_ppu, is_ppu;
      n = int'(g_c_on) + int'(g_p_on);
      got = 0; budget = 0;
      while (got < n && budget < 60) begin
         @(posedge clock); #1;
         budget++;
         if (cpu_ack) begin cpu_req = 1'b0; got++; end
         if (ppu_ack) begin ppu_req = 1'b0; got++; end
      end
      chk("acks_seen", 32'(got), 32'(n));
      @(negedge clock); #1;
      chk("strobe_count", 32'(sq.size()), 32'(n));
      chk("ack_count", 32'(aq.size()), 32'(n));
      if (sq.size() == n && aq.size() == n) begin
         first_ppu = model_pick_ppu(g_c_on, g_p_on);
         exp_strb  = t0 + 1;
         for (int i = 0; i < n; i++) begin
            is_ppu = (i == 0) ? first_ppu : !first_ppu;
            kind   = is_ppu ? 2 : (g_c_we ? 3 : 1);
            lat    = (kind == 3) ? 1 : int'(TB_LAT) + 1;
            chk("strb_kind", 32'(sq[i].kind), 32'(kind));
            chk("strb_addr", 32'(sq[i].addr), 32'(is_ppu ? g_p_addr : g_c_addr));
            chk("strb_cyc", 32'(sq[i].cyc), 32'(exp_strb));
            if (kind == 3) chk("strb_wdata", 32'(sq[i].d), 32'(g_c_wd));
            if (kind == 1) m_crd = mem_val(g_c_addr, 1'b0);
            if (kind == 2) m_prd = mem_val(g_p_addr, 1'b1);
            chk("ack_who", 32'(aq[i].who), 32'(is_ppu));
            chk("ack_cyc", 32'(aq[i].cyc), 32'(exp_strb + lat));
            chk("cpu_rdata", 32'(aq[i].crd), 32'(m_crd));
            chk("ppu_rdata", 32'(aq[i].prd), 32'(m_prd));
            model_ptr_set(!is_ppu);
            exp_strb = exp_strb + lat + 2;
         end
         last_ack_cyc = aq[n-1].cyc;
      end
      sq.delete();
      aq.delete();
   endtask

   task automatic txn(input bit c_on, input bit c_we, input logic [AW-1:0] c_addr,
                      input logic [7:0] c_wd, input bit p_on, input logic [AW-1:0] p_addr);
      @(posedge clock); #1;
      txn_start(c_on, c_we, c_addr, c_wd, p_on, p_addr);
      txn_finish(cyc);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rd_cpu"}, 32'(mem_rd_cpu), 32'd0);
      chk({tag, "_rd_ppu"}, 32'(mem_rd_ppu), 32'd0);
      chk({tag, "_wr"}, 32'(mem_wr), 32'd0);
      chk({tag, "_mem_d"}, 32'(mem_d), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
      chk({tag, "_ppu_ack"}, 32'(ppu_ack), 32'd0);
      chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
      chk({tag, "_ppu_rdata"}, 32'(ppu_rdata), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   int prev_ack;
   bit rc, rp;
   initial begin
      // 1: reset with a pending CPU read and load_done low; release at cycle 10.
      txn_start(1'b1, 1'b0, 22'h000000, 8'h00, 1'b0, 22'h0);
      #1;
      chk_outputs_zero("reset");
      while (cyc < 3) begin @(posedge clock); #1; end
      reset_n = 1'b1;
      while (cyc < 10) begin @(posedge clock); #1; end
      chk("t1_no_strobe_before_load", 32'(sq.size()), 32'd0);
      chk("t1_idle_before_load", 32'(busy), 32'd0);
      load_done = 1'b1;
      txn_finish(cyc);
      chk("t1_rdata_5a", 32'(cpu_rdata), 32'h5A);

      // 2: CPU write.
      txn(1'b1, 1'b1, 22'h380005, 8'hC3, 1'b0, 22'h0);

      // 3: simultaneous CPU and PPU requests, four back-to-back pairs.
      for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, 22'h001234, 8'h00, 1'b1, 22'h200010);

      // 4: back-to-back PPU reads, check ack spacing.
      for (int i = 0; i < 4; i++) begin
         prev_ack = last_ack_cyc;
         txn(1'b0, 1'b0, 22'h0, 8'h00, 1'b1, 22'h200020 + 22'(i));
         if (i > 0) chk("t4_ppu_ack_spacing", 32'(last_ack_cyc - prev_ack), 32'(TB_LAT + 3));
      end

      // 5: reset asserted during WAIT, then the still-pending request is re-served.
      @(posedge clock); #1;
      txn_start(1'b1, 1'b0, 22'h3A0F0F, 8'h00, 1'b0, 22'h0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      #2;
      reset_n = 1'b0;
      #1;
      chk_outputs_zero("t5_async");
      repeat (2) @(posedge clock);
      #1;
      chk("t5_no_ack_in_reset", 32'(aq.size()), 32'd0);
      sq.delete();
      reset_n = 1'b1;
      model_ptr_set(1'b0);
      m_crd = '0;
      m_prd = '0;
      txn_finish(cyc);

      // 6: load_done drops during a CPU read; later PPU request waits for it.
      @(posedge clock); #1;
      txn_start(1'b1, 1'b0, 22'h0C0077, 8'h00, 1'b0, 22'h0);
      prev_ack = cyc;
      @(posedge clock); #1;
      @(posedge clock); #1;
      load_done = 1'b0;
      txn_finish(prev_ack);
      @(posedge clock); #1;
      txn_start(1'b0, 1'b0, 22'h0, 8'h00, 1'b1, 22'h2ABCDE);
      repeat (8) @(posedge clock);
      #1;
      chk("t6_no_strobe_while_unloaded", 32'(sq.size()), 32'd0);
      chk("t6_idle_while_unloaded", 32'(busy), 32'd0);
      load_done = 1'b1;
      txn_finish(cyc);

      // Random mix of reads, writes and contention.
      for (int i = 0; i < 30; i++) begin
         rc = 1'($urandom);
         rp = 1'($urandom);
         if (!rc && !rp) rc = 1'b1;
         txn(rc, 1'($urandom), rand_addr(), 8'($urandom), rp, rand_addr());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
